dram_message_reader: RTL and testbench

//  Reader side of the decrypted-message RAM (D_RAM) that the RC4 decrypt FSM writes.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/ascii_lower_check.sv | 12 +
 rtl/dram_message_reader.sv | 204 ++++++++++++++++++++
 tb/tb_dram_message_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 cracker constants, including the D_RAM reader state encoding.
// The reader's KEY states are only entered when STREAM_KEY_EN is defined.
package rc4_pkg;

  localparam int         MSG_LEN_DEFAULT = 32;
  localparam int         KEY_W           = 24;
  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_LO        = 8'h61;
  localparam logic [7:0] ASCII_HI        = 8'h7A;

  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_KEY0 = 3'd1,
    RD_KEY1 = 3'd2,
    RD_KEY2 = 3'd3,
    RD_ADDR = 3'd4,
    RD_WAIT = 3'd5,
    RD_SEND = 3'd6,
    RD_DONE = 3'd7
  } reader_state_t;

endpackage

// File: rtl/ascii_lower_check.sv
// Flags whether a byte is a lowercase ASCII letter or a space.
// Purely combinational so the cracking FSM can reuse it on its own datapath.
module ascii_lower_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       ok
);

  assign ok = (data == ASCII_SPACE) || ((data >= ASCII_LO) && (data <= ASCII_HI));

endmodule

// File: rtl/dram_message_reader.sv
// Reads MSG_LEN decrypted bytes from D_RAM and streams them on a valid/ready byte port.
// Define STREAM_KEY_EN to prefix the stream with the three secret-key bytes, MSB first.
module dram_message_reader
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  secret_key,
  output logic [ADDR_W-1:0] d_ram_addr,
  input  logic [7:0]        d_ram_q,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              char_err
);

  // One extra index bit so MSG_LEN=256 reaches its last index without wrapping.
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]   ZERO_IDX  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_IDX   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  reader_state_t     state_r, state_nxt_s;
  logic [ADDR_W:0]   index_r, index_s, index_inc_s;
  logic [KEY_W-1:0]  key_r, key_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        data_r, data_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              hs_s, last_s, q_ok_s;

  ascii_lower_check u_ascii_check (
    .data (d_ram_q),
    .ok   (q_ok_s)
  );

  assign hs_s        = valid_r && out_ready;
  assign last_s      = (index_r == LAST_IDX);
  assign index_inc_s = index_r + ONE_IDX;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (start) begin
`ifdef STREAM_KEY_EN
          state_nxt_s = RD_KEY0;
`else
          state_nxt_s = RD_ADDR;
`endif
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
`ifdef STREAM_KEY_EN
      RD_KEY0: state_nxt_s = hs_s ? RD_KEY1 : RD_KEY0;
      RD_KEY1: state_nxt_s = hs_s ? RD_KEY2 : RD_KEY1;
      RD_KEY2: state_nxt_s = hs_s ? RD_ADDR : RD_KEY2;
`endif
      RD_ADDR: state_nxt_s = RD_WAIT;
      RD_WAIT: state_nxt_s = RD_SEND;
      RD_SEND: begin
        if (hs_s) begin
          state_nxt_s = last_s ? RD_DONE : RD_ADDR;
        end else begin
          state_nxt_s = RD_SEND;
        end
      end
      RD_DONE: state_nxt_s = RD_IDLE;
      default: state_nxt_s = RD_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; the address leads the RAM by one cycle.
  always_comb begin
    index_s = index_r;
    key_s   = key_r;
    addr_s  = addr_r;
    data_s  = data_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = err_r;
    case (state_r)
      RD_IDLE: begin
        if (start) begin
          key_s   = secret_key;
          index_s = ZERO_IDX;
          err_s   = 1'b0;
          busy_s  = 1'b1;
`ifdef STREAM_KEY_EN
          data_s  = secret_key[23:16];
          valid_s = 1'b1;
`else
          addr_s  = ZERO_ADDR;
`endif
        end else begin
          busy_s = 1'b0;
        end
      end
`ifdef STREAM_KEY_EN
      RD_KEY0: begin
        if (hs_s) begin
          data_s = key_r[15:8];
        end else begin
          data_s = data_r;
        end
      end
      RD_KEY1: begin
        if (hs_s) begin
          data_s = key_r[7:0];
        end else begin
          data_s = data_r;
        end
      end
      RD_KEY2: begin
        if (hs_s) begin
          valid_s = 1'b0;
          addr_s  = ZERO_ADDR;
        end else begin
          valid_s = 1'b1;
        end
      end
`endif
      RD_WAIT: begin
        data_s  = d_ram_q;
        valid_s = 1'b1;
        if (!q_ok_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end
      RD_SEND: begin
        if (hs_s) begin
          valid_s = 1'b0;
          if (last_s) begin
            done_s = 1'b1;
          end else begin
            index_s = index_inc_s;
            addr_s  = index_inc_s[ADDR_W-1:0];
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      RD_DONE: begin
        busy_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_r <= ZERO_IDX;
      key_r   <= {KEY_W{1'b0}};
      addr_r  <= ZERO_ADDR;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      index_r <= index_s;
      key_r   <= key_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign d_ram_addr = addr_r;
  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign char_err   = err_r;

endmodule

// File: tb/tb_dram_message_reader.sv
// Directed bench for dram_message_reader: a behavioural D_RAM plus a handshaking byte sink.
module tb_dram_message_reader;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [23:0] secret_key;
  logic [7:0]  d_ram_addr, d_ram_q, out_data;
  logic        out_valid, busy, done, char_err;

  logic [7:0]   mem    [0:255];
  logic [7:0]   exp_b  [0:31];
  logic [7:0]   rx     [0:63];
  logic         err_at [0:63];
  logic [255:0] msg_text;
  int n_vec = 0, n_err = 0;
  int rx_n, hold_err, done_cnt, first_valid_c;
  logic busy_c1, err_c1;

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the presented address appears one clock later.
  always @(posedge clk) d_ram_q <= mem[d_ram_addr];

  dram_message_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret_key (secret_key),
    .d_ram_addr (d_ram_addr),
    .d_ram_q    (d_ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .char_err   (char_err)
  );

  task automatic load_msg();
    msg_text = "attack at dawn and hold the line";
    for (int i = 0; i < 32; i++) begin
      exp_b[i] = msg_text[255-8*i -: 8];
      mem[i]   = exp_b[i];
    end
    for (int i = 32; i < 256; i++) mem[i] = 8'hEE;
  endtask

  // Pulses start, then acts as the sink until a few cycles past done (or stop_at bytes taken).
  task automatic collect(input int ready_pct, input int restart_at, input int stop_at,
                         input logic [23:0] key);
    logic pv, pr, restarted;
    logic [7:0] pd;
    int since_done;
    rx_n = 0; hold_err = 0; done_cnt = 0; first_valid_c = -1;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; since_done = -1; restarted = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rx[i] = 8'hxx;
      err_at[i] = 1'bx;
    end
    @(negedge clk);
    start = 1'b1; secret_key = key; out_ready = 1'b1;
    for (int c = 1; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        busy_c1 = busy;
        err_c1  = char_err;
      end
      if (out_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
      if (done === 1'b1) done_cnt++;
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) hold_err++;
      if (since_done >= 0) since_done++;
      if (done === 1'b1 && since_done < 0) since_done = 0;
      if (since_done >= 4) break;
      if (stop_at >= 0 && rx_n == stop_at && out_valid === 1'b1) break;
      if (restart_at >= 0 && rx_n == restart_at && !restarted) begin
        start = 1'b1; secret_key = ~key; restarted = 1'b1;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid === 1'b1 && out_ready && rx_n < 64) begin
        rx[rx_n] = out_data;
        err_at[rx_n] = char_err;
        rx_n++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; secret_key = 24'h000000;
    #3 rst = 1'b0;
    #1;
    n_vec++; if (d_ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", d_ram_addr); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (char_err !== 1'b0) begin n_err++; $display("FAIL reset_char_err got %b want 0", char_err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    load_msg();
    collect(100, -1, -1, 24'hABCDEF);
    n_vec++; if (first_valid_c !== 3) begin n_err++; $display("FAIL basic_latency got %0d want 3", first_valid_c); end
    n_vec++; if (busy_c1 !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy_c1); end
    n_vec++; if (rx_n !== 32) begin n_err++; $display("FAIL basic_count got %0d want 32", rx_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i] !== exp_b[i]) begin n_err++; $display("FAIL basic_byte[%0d] got %h want %h", i, rx[i], exp_b[i]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_vec++; if (char_err !== 1'b0) begin n_err++; $display("FAIL basic_char_err got %b want 0", char_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_stall();
    load_msg();
    collect(50, -1, -1, 24'h123456);
    n_vec++; if (rx_n !== 32) begin n_err++; $display("FAIL stall_count got %0d want 32", rx_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i] !== exp_b[i]) begin n_err++; $display("FAIL stall_byte[%0d] got %h want %h", i, rx[i], exp_b[i]); end
    end
    n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL stall_hold got %0d want 0", hold_err); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_char_err();
    load_msg();
    mem[5] = 8'h41;
    exp_b[5] = 8'h41;
    collect(100, -1, -1, 24'h000001);
    n_vec++; if (rx_n !== 32) begin n_err++; $display("FAIL cerr_count got %0d want 32", rx_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i] !== exp_b[i]) begin n_err++; $display("FAIL cerr_byte[%0d] got %h want %h", i, rx[i], exp_b[i]); end
      n_vec++; if (err_at[i] !== (i >= 5)) begin n_err++; $display("FAIL cerr_flag[%0d] got %b want %b", i, err_at[i], (i >= 5)); end
    end
    n_vec++; if (char_err !== 1'b1) begin n_err++; $display("FAIL cerr_sticky got %b want 1", char_err); end
  endtask

  task automatic test_back_to_back();
    load_msg();
    collect(70, 10, -1, 24'h55AA55);
    n_vec++; if (err_c1 !== 1'b0) begin n_err++; $display("FAIL b2b_err_clear got %b want 0", err_c1); end
    n_vec++; if (rx_n !== 32) begin n_err++; $display("FAIL b2b_count got %0d want 32", rx_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_byte[%0d] got %h want %h", i, rx[i], exp_b[i]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
    n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL b2b_hold got %0d want 0", hold_err); end
  endtask

  task automatic test_reset_mid();
    load_msg();
    collect(100, -1, 12, 24'h0F0F0F);
    n_vec++; if (rx_n !== 12) begin n_err++; $display("FAIL mid_count got %0d want 12", rx_n); end
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got %b want 0", done); end
    n_vec++; if (d_ram_addr !== 8'h00) begin n_err++; $display("FAIL mid_addr got %h want 00", d_ram_addr); end
    @(negedge clk);
    rst = 1'b1;
    collect(100, -1, -1, 24'h0F0F0F);
    n_vec++; if (rx_n !== 32) begin n_err++; $display("FAIL mid_restart_count got %0d want 32", rx_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i] !== exp_b[i]) begin n_err++; $display("FAIL mid_byte[%0d] got %h want %h", i, rx[i], exp_b[i]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL mid_done_cnt got %0d want 1", done_cnt); end
  endtask

`ifdef STREAM_KEY_EN
  task automatic test_key();
    load_msg();
    collect(100, -1, -1, 24'h0003FF);
    n_vec++; if (rx_n !== 35) begin n_err++; $display("FAIL key_count got %0d want 35", rx_n); end
    n_vec++; if (rx[0] !== 8'h00) begin n_err++; $display("FAIL key_b0 got %h want 00", rx[0]); end
    n_vec++; if (rx[1] !== 8'h03) begin n_err++; $display("FAIL key_b1 got %h want 03", rx[1]); end
    n_vec++; if (rx[2] !== 8'hFF) begin n_err++; $display("FAIL key_b2 got %h want ff", rx[2]); end
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (rx[i+3] !== exp_b[i]) begin n_err++; $display("FAIL key_msg[%0d] got %h want %h", i, rx[i+3], exp_b[i]); end
    end
    n_vec++; if (char_err !== 1'b0) begin n_err++; $display("FAIL key_char_err got %b want 0", char_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_char_err();
    test_back_to_back();
    test_reset_mid();
`ifdef STREAM_KEY_EN
    test_key();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
